demux1to8_sipo: RTL and testbench

Sequential 1-to-8 demultiplexer and serial-to-parallel collector, the receive-side counterpart of the team's 8:1 selector. A single-bit input stream is steered into eight output lanes either by an explicit lane address or by an internal scan counter. In scan mode the block assembles 8-bit frames and hands them downstream over a valid/ready handshake. It sits between a serial source, such as a selector-driven serializer, and parallel consumers.

---
 rtl/demux1to8_sipo.sv | 81 ++++++++
 tb/tb_demux1to8_sipo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demux1to8_sipo.sv
// Serial 1-to-8 demultiplexer / SIPO collector: addressed lane writes, or
// scan-mode 8-bit frame assembly handed downstream over valid/ready.
module demux1to8_sipo #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    input  logic       mode,
    input  logic [2:0] sel,
    input  logic       clr,
    input  logic       out_ready,
    output logic [7:0] q,
    output logic       out_valid,
    output logic       overrun,
    output logic [2:0] idx
);

    typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

    state_t     state;
    logic       mode_q;
    logic [7:0] stage;

    logic       mode_chg;
    logic [2:0] cnt;
    logic [2:0] lane;
    logic [7:0] stg;
    logic [7:0] frame;
    logic       consume;

    assign out_valid = (state == FULL);

    // A mode change restarts the frame; the same cycle's bit is taken at count 0.
    always_comb begin
        mode_chg    = (mode != mode_q);
        cnt         = mode_chg ? 3'd0 : idx;
        stg         = mode_chg ? 8'h00 : stage;
        lane        = LSB_FIRST ? cnt : (3'd7 - cnt);
        frame       = stg;
        frame[lane] = din;
        consume     = out_valid & out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q       <= 8'h00;
            state   <= COLLECT;
            overrun <= 1'b0;
            idx     <= 3'd0;
            stage   <= 8'h00;
            mode_q  <= mode;
        end else begin
            mode_q <= mode;
            idx    <= cnt;
            stage  <= stg;
            if (consume)
                state <= COLLECT;
            if (!mode) begin
                if (din_valid)
                    q[sel] <= din;
            end else if (din_valid) begin
                if (cnt != 3'd7) begin
                    stage[lane] <= din;
                    idx         <= cnt + 3'd1;
                end else begin
                    // Completion reloads q even when a frame is pending; a
                    // same-cycle consume saves the old frame from overrun.
                    q     <= frame;
                    state <= FULL;
                    idx   <= 3'd0;
                    stage <= 8'h00;
                    if (out_valid && !out_ready)
                        overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux1to8_sipo.sv
// Directed bench for demux1to8_sipo; both scan orders run side by side on
// shared stimulus, with a frame scoreboard per instance.
module tb_demux1to8_sipo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       clr = 1'b0;
    logic       out_ready = 1'b0;

    logic [7:0] q0, q1;
    logic       ov0, ov1, ovr0, ovr1;
    logic [2:0] idx0, idx1;

    int npass = 0;
    int ntot  = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    always #5 clk = ~clk;

    demux1to8_sipo #(.LSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .mode(mode),
        .sel(sel), .clr(clr), .out_ready(out_ready),
        .q(q0), .out_valid(ov0), .overrun(ovr0), .idx(idx0)
    );

    demux1to8_sipo #(.LSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .mode(mode),
        .sel(sel), .clr(clr), .out_ready(out_ready),
        .q(q1), .out_valid(ov1), .overrun(ovr1), .idx(idx1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] rev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // seq[0] is the first bit in time; gaps of 0..maxgap idle cycles precede each bit.
    task automatic send_bits(input logic [7:0] seq, input int n, input int maxgap,
                             input logic rdy_last, input logic pre_chk);
        int g;
        for (int i = 0; i < n; i++) begin
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (g) begin
                din_valid = 1'b0;
                out_ready = 1'b0;
                step();
            end
            if (i == 7 && pre_chk) chk("pre_last_valid", {7'd0, ov0}, 8'h00);
            din       = seq[i];
            din_valid = 1'b1;
            out_ready = (i == 7) ? rdy_last : 1'b0;
            if (i == 7) begin
                exp0.push_back(seq);
                exp1.push_back(rev(seq));
            end
            step();
        end
        din_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] e0, e1;
        if (exp0.size() == 0 || exp1.size() == 0) begin
            ntot++;
            $error("FAIL %s: got empty scoreboard expected a frame", tag);
        end else begin
            e0 = exp0.pop_front();
            e1 = exp1.pop_front();
            chk({tag, "_q_lsb"}, q0, e0);
            chk({tag, "_q_msb"}, q1, e1);
            chk({tag, "_valid"}, {7'd0, ov0}, 8'h01);
            chk({tag, "_idx"}, {5'd0, idx0}, 8'h00);
        end
    endtask

    task automatic consume();
        din_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] eq;
        logic [7:0] b;

        // Reset with data present
        rst = 1'b1; din_valid = 1'b1; din = 1'b1; mode = 1'b0; sel = 3'd0;
        step(); step();
        chk("rst_q", q0, 8'h00);
        chk("rst_valid", {7'd0, ov0}, 8'h00);
        chk("rst_overrun", {7'd0, ovr0}, 8'h00);
        chk("rst_idx", {5'd0, idx0}, 8'h00);
        rst = 1'b0; din_valid = 1'b0;

        // Addressed writes
        eq = 8'h00;
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k); din = 1'b1; din_valid = 1'b1;
            eq[k] = 1'b1;
            step();
            chk("addr_q", q0, eq);
        end
        chk("addr_valid", {7'd0, ov0}, 8'h00);
        sel = 3'd3; din = 1'b0;
        step();
        din_valid = 1'b0;
        chk("addr_q_f7", q0, 8'hF7);
        chk("addr_q_f7_msb", q1, 8'hF7);
        chk("addr_valid2", {7'd0, ov0}, 8'h00);

        // Scan, both orders
        mode = 1'b1;
        send_bits(8'hA5, 8, 0, 1'b0, 1'b1);
        check_frame("scan_a5");
        consume();
        chk("consume_valid", {7'd0, ov0}, 8'h00);
        chk("consume_q_hold", q0, 8'hA5);
        send_bits(8'h03, 8, 0, 1'b0, 1'b1);
        check_frame("scan_c0");
        chk("scan_no_overrun", {7'd0, ovr0}, 8'h00);
        consume();

        // Overrun, clear, simultaneous consume
        send_bits(8'h3C, 8, 0, 1'b0, 1'b0);
        check_frame("ovr_3c");
        send_bits(8'h5A, 8, 0, 1'b0, 1'b0);
        check_frame("ovr_5a");
        chk("overrun_lsb", {7'd0, ovr0}, 8'h01);
        chk("overrun_msb", {7'd0, ovr1}, 8'h01);
        clr = 1'b1; din_valid = 1'b1; din = 1'b1;
        step();
        clr = 1'b0; din_valid = 1'b0;
        chk("clr_q", q0, 8'h00);
        chk("clr_valid", {7'd0, ov0}, 8'h00);
        chk("clr_overrun", {7'd0, ovr0}, 8'h00);
        chk("clr_idx", {5'd0, idx0}, 8'h00);
        send_bits(8'h3C, 8, 0, 1'b0, 1'b0);
        check_frame("sim_3c");
        send_bits(8'h5A, 8, 0, 1'b1, 1'b0);
        check_frame("sim_5a");
        chk("sim_no_overrun", {7'd0, ovr0}, 8'h00);
        consume();
        chk("sim_drain_valid", {7'd0, ov0}, 8'h00);
        chk("sim_drain_q", q0, 8'h5A);

        // Mid-frame mode toggle discards partial frame
        send_bits(8'hFF, 4, 0, 1'b0, 1'b0);
        chk("partial_idx", {5'd0, idx0}, 8'h04);
        mode = 1'b0;
        step();
        chk("toggle_idx", {5'd0, idx0}, 8'h00);
        chk("toggle_q_hold", q0, 8'h5A);
        mode = 1'b1;
        step();
        chk("toggle_back_idx", {5'd0, idx0}, 8'h00);
        send_bits(8'h96, 8, 0, 1'b0, 1'b1);
        check_frame("clean_96");
        consume();

        // Reset mid-frame
        send_bits(8'hFF, 5, 0, 1'b0, 1'b0);
        chk("partial5_idx", {5'd0, idx0}, 8'h05);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_idx", {5'd0, idx0}, 8'h00);
        chk("midrst_q", q0, 8'h00);
        chk("midrst_valid", {7'd0, ov0}, 8'h00);

        // Gapped input
        for (int r = 0; r < 3; r++) begin
            b = 8'($urandom);
            send_bits(b, 8, 3, 1'b0, 1'b1);
            check_frame("gapped");
            consume();
            chk("gapped_drain", {7'd0, ov0}, 8'h00);
        end
        chk("gapped_overrun", {7'd0, ovr0}, 8'h00);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
